// File: rtl/accel_pkg.sv
// Shared accelerometer definitions: sample width, filter FSM states and the
// 17-to-16-bit saturation helper used wherever a difference must fit a sample.
package accel_pkg;

  localparam int ACCEL_W     = 16;
  localparam int Z_ONE_G_DEF = 256;

  localparam logic signed [ACCEL_W:0] ACCEL_MAX = 17'sd32767;
  localparam logic signed [ACCEL_W:0] ACCEL_MIN = -17'sd32768;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_X = 3'd1,
    ACC_Y = 3'd2,
    ACC_Z = 3'd3,
    OUT   = 3'd4
  } accel_state_e;

  // Clamp a 17-bit signed difference into the 16-bit sample range.
  function automatic logic signed [ACCEL_W-1:0] sat_to_accel(input logic signed [ACCEL_W:0] v);
    if (v > ACCEL_MAX)
      return ACCEL_MAX[ACCEL_W-1:0];
    else if (v < ACCEL_MIN)
      return ACCEL_MIN[ACCEL_W-1:0];
    else
      return v[ACCEL_W-1:0];
  endfunction

endpackage

// File: rtl/accel_sat_sub.sv
// Combinational signed subtract a - b, widened to 17 bits and saturated back to 16.
module accel_sat_sub
  import accel_pkg::*;
(
  input  logic signed [ACCEL_W-1:0] a,
  input  logic signed [ACCEL_W-1:0] b,
  output logic signed [ACCEL_W-1:0] diff
);

  logic signed [ACCEL_W:0] wide;

  // Sign-extend both operands so the difference never wraps before clamping.
  always_comb begin
    wide = {a[ACCEL_W-1], a} - {b[ACCEL_W-1], b};
    diff = sat_to_accel(wide);
  end

endmodule

// File: rtl/accel_avg_filter.sv
// Block-averaging filter for ADXL345 X/Y/Z samples. One adder is shared across
// the three axes by stepping an FSM through ACC_X/ACC_Y/ACC_Z; every
// 2^AVG_LOG2 samples the averages are offset-corrected, saturated and
// published together with an |X| tilt bar-graph.
module accel_avg_filter
  import accel_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int Z_ONE_G   = Z_ONE_G_DEF,
  parameter int LED_SHIFT = 6
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic signed [ACCEL_W-1:0] accel_x_in,
  input  logic signed [ACCEL_W-1:0] accel_y_in,
  input  logic signed [ACCEL_W-1:0] accel_z_in,
  input  logic                      cal_req,
  input  logic                      clear_flags,
  output logic signed [ACCEL_W-1:0] filt_x,
  output logic signed [ACCEL_W-1:0] filt_y,
  output logic signed [ACCEL_W-1:0] filt_z,
  output logic                      filt_valid,
  output logic                      cal_done,
  output logic                      busy,
  output logic                      drop_flag,
  output logic [7:0]                led
);

  localparam int ACC_W = ACCEL_W + AVG_LOG2;
  localparam int NSMP  = 1 << AVG_LOG2;

  accel_state_e state, state_nxt;

  logic signed [ACCEL_W-1:0] smp_x_p0, smp_y_p0, smp_z_p0;
  logic signed [ACC_W-1:0]   acc_x, acc_y, acc_z;
  logic [AVG_LOG2-1:0]       cnt;
  logic                      cal_pending;
  logic signed [ACCEL_W-1:0] off_x, off_y, off_z;

  logic signed [ACC_W-1:0]   add_acc, add_smp, add_sum;
  logic signed [ACCEL_W-1:0] add_in;
  logic signed [ACCEL_W-1:0] avg_x, avg_y, avg_z, cal_z;
  logic signed [ACCEL_W-1:0] eoff_x, eoff_y, eoff_z;
  logic signed [ACCEL_W-1:0] fx, fy, fz;
  logic [ACCEL_W-1:0]        fx_abs, fx_bar;
  logic [3:0]                led_n;
  logic [7:0]                led_nxt;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one cycle per axis, OUT only at the end of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid) state_nxt = ACC_X;
      ACC_X:   state_nxt = ACC_Y;
      ACC_Y:   state_nxt = ACC_Z;
      ACC_Z:   state_nxt = (cnt == AVG_LOG2'(NSMP - 1)) ? OUT : IDLE;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: anything past IDLE refuses new samples.
  always_comb begin
    busy = (state != IDLE);
  end

  // The single shared adder: state picks which axis accumulates this cycle.
  always_comb begin
    add_acc = acc_x;
    add_in  = smp_x_p0;
    case (state)
      ACC_Y: begin add_acc = acc_y; add_in = smp_y_p0; end
      ACC_Z: begin add_acc = acc_z; add_in = smp_z_p0; end
      default: ;
    endcase
    add_smp = {{AVG_LOG2{add_in[ACCEL_W-1]}}, add_in};
    add_sum = add_acc + add_smp;
  end

  // Frame averages (floor via arithmetic shift) and the offsets in force this frame.
  always_comb begin
    avg_x  = ACCEL_W'(acc_x >>> AVG_LOG2);
    avg_y  = ACCEL_W'(acc_y >>> AVG_LOG2);
    avg_z  = ACCEL_W'(acc_z >>> AVG_LOG2);
    cal_z  = sat_to_accel({avg_z[ACCEL_W-1], avg_z} - (ACCEL_W+1)'(Z_ONE_G));
    eoff_x = cal_pending ? avg_x : off_x;
    eoff_y = cal_pending ? avg_y : off_y;
    eoff_z = cal_pending ? cal_z : off_z;
  end

  accel_sat_sub u_sub_x (.a(avg_x), .b(eoff_x), .diff(fx));
  accel_sat_sub u_sub_y (.a(avg_y), .b(eoff_y), .diff(fy));
  accel_sat_sub u_sub_z (.a(avg_z), .b(eoff_z), .diff(fz));

  // Tilt bar-graph from |X|; the most negative code folds onto full scale.
  always_comb begin
    if (fx == ACCEL_MIN[ACCEL_W-1:0])
      fx_abs = ACCEL_MAX[ACCEL_W-1:0];
    else if (fx < 0)
      fx_abs = -fx;
    else
      fx_abs = fx;
    fx_bar  = fx_abs >> LED_SHIFT;
    led_n   = (fx_bar > 16'd8) ? 4'd8 : fx_bar[3:0];
    led_nxt = 8'((9'd1 << led_n) - 9'd1);
  end

  // Sample capture, accumulation, frame counter and accumulator clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      smp_x_p0 <= '0;
      smp_y_p0 <= '0;
      smp_z_p0 <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      acc_z    <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (sample_valid) begin
          smp_x_p0 <= accel_x_in;
          smp_y_p0 <= accel_y_in;
          smp_z_p0 <= accel_z_in;
        end
        ACC_X: acc_x <= add_sum;
        ACC_Y: acc_y <= add_sum;
        ACC_Z: begin
          acc_z <= add_sum;
          cnt   <= cnt + 1'b1;
        end
        OUT: begin
          acc_x <= '0;
          acc_y <= '0;
          acc_z <= '0;
        end
        default: ;
      endcase
    end
  end

  // Frame publication and offset capture when a calibration is pending.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      filt_x     <= '0;
      filt_y     <= '0;
      filt_z     <= '0;
      led        <= '0;
      filt_valid <= 1'b0;
      cal_done   <= 1'b0;
      off_x      <= '0;
      off_y      <= '0;
      off_z      <= '0;
    end else begin
      filt_valid <= 1'b0;
      cal_done   <= 1'b0;
      if (state == OUT) begin
        filt_x     <= fx;
        filt_y     <= fy;
        filt_z     <= fz;
        led        <= led_nxt;
        filt_valid <= 1'b1;
        if (cal_pending) begin
          off_x    <= eoff_x;
          off_y    <= eoff_y;
          off_z    <= eoff_z;
          cal_done <= 1'b1;
        end
      end
    end
  end

  // Calibration request latch; a request landing on OUT carries to the next frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) cal_pending <= 1'b0;
    else       cal_pending <= cal_req | (cal_pending & (state != OUT));
  end

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                       drop_flag <= 1'b0;
    else if (sample_valid && busy)   drop_flag <= 1'b1;
    else if (clear_flags)            drop_flag <= 1'b0;
  end

endmodule

// File: tb/tb_accel_avg_filter.sv
// Randomised bench for accel_avg_filter against a frame-level arithmetic model.
module tb_accel_avg_filter;

  localparam int NS = 8;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] accel_x_in = '0, accel_y_in = '0, accel_z_in = '0;
  logic               cal_req = 1'b0, clear_flags = 1'b0;
  logic signed [15:0] filt_x, filt_y, filt_z;
  logic               filt_valid, cal_done, busy, drop_flag;
  logic [7:0]         led;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state.
  int m_sum[3];
  int m_n;
  int m_off[3];
  bit m_cal;

  accel_avg_filter #(.AVG_LOG2(3), .Z_ONE_G(256), .LED_SHIFT(6)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid),
    .accel_x_in(accel_x_in), .accel_y_in(accel_y_in), .accel_z_in(accel_z_in),
    .cal_req(cal_req), .clear_flags(clear_flags),
    .filt_x(filt_x), .filt_y(filt_y), .filt_z(filt_z), .filt_valid(filt_valid),
    .cal_done(cal_done), .busy(busy), .drop_flag(drop_flag), .led(led)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int floor_avg(input int s);
    int q;
    q = s / NS;
    if (s < 0 && (s % NS) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [7:0] led_of(input int f);
    int a, n;
    a = (f < 0) ? -f : f;
    if (a > 32767) a = 32767;
    n = a / 64;
    if (n > 8) n = 8;
    return 8'((1 << n) - 1);
  endfunction

  function automatic int rnd16();
    logic [31:0] r;
    r = $urandom;
    return int'($signed(r[15:0]));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_off[k] = 0; end
    m_n = 0;
    m_cal = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // inj=1 injects a strobe 2 cycles after acceptance, inj=2 adds clear_flags to it.
  task automatic accept_sample(input int x, input int y, input int z, input int inj, input int gap);
    int avg[3], ef[3];
    bit frame, ecd;
    logic [15:0] exv;
    sample_valid = 1'b1;
    accel_x_in = 16'(x); accel_y_in = 16'(y); accel_z_in = 16'(z);
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
    m_sum[0] += x; m_sum[1] += y; m_sum[2] += z;
    m_n++;
    frame = (m_n == NS);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (filt_valid !== 1'b0) begin n_fail++; $display("FAIL filt_valid_early: cycle T+%0d got %b want 0", i, filt_valid); end
      if (i == 1 && inj != 0) begin
        sample_valid = 1'b1;
        accel_x_in = 16'sh7abc; accel_y_in = -16'sh3000; accel_z_in = 16'sh5555;
        clear_flags = (inj == 2);
      end
      if (i == 2 && inj != 0) begin
        n_checks++;
        if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL drop_flag_set: inj=%0d got %b want 1", inj, drop_flag); end
      end
      @(negedge CLOCK_50);
      sample_valid = 1'b0;
      clear_flags = 1'b0;
    end
    if (frame) begin
      for (int k = 0; k < 3; k++) avg[k] = floor_avg(m_sum[k]);
      ecd = m_cal;
      if (m_cal) begin
        m_off[0] = avg[0]; m_off[1] = avg[1]; m_off[2] = sat16(avg[2] - 256);
        m_cal = 0;
      end
      for (int k = 0; k < 3; k++) ef[k] = sat16(avg[k] - m_off[k]);
      n_checks++;
      if (filt_valid !== 1'b0) begin n_fail++; $display("FAIL filt_valid_early: cycle T+3 got %b want 0", filt_valid); end
      @(negedge CLOCK_50);
      n_checks++;
      if (filt_valid !== 1'b1) begin n_fail++; $display("FAIL filt_valid_pulse: got %b want 1", filt_valid); end
      exv = 16'(ef[0]);
      n_checks++;
      if (filt_x !== exv) begin n_fail++; $display("FAIL filt_x: got %0d want %0d", filt_x, ef[0]); end
      exv = 16'(ef[1]);
      n_checks++;
      if (filt_y !== exv) begin n_fail++; $display("FAIL filt_y: got %0d want %0d", filt_y, ef[1]); end
      exv = 16'(ef[2]);
      n_checks++;
      if (filt_z !== exv) begin n_fail++; $display("FAIL filt_z: got %0d want %0d", filt_z, ef[2]); end
      n_checks++;
      if (led !== led_of(ef[0])) begin n_fail++; $display("FAIL led: got %h want %h", led, led_of(ef[0])); end
      n_checks++;
      if (cal_done !== ecd) begin n_fail++; $display("FAIL cal_done: got %b want %b", cal_done, ecd); end
      @(negedge CLOCK_50);
      n_checks++;
      if (filt_valid !== 1'b0 || cal_done !== 1'b0) begin
        n_fail++; $display("FAIL pulse_width: filt_valid=%b cal_done=%b want 0 0", filt_valid, cal_done);
      end
      for (int k = 0; k < 3; k++) m_sum[k] = 0;
      m_n = 0;
    end
    repeat (gap) @(negedge CLOCK_50);
  endtask

  task automatic pulse_cal();
    cal_req = 1'b1;
    @(negedge CLOCK_50);
    cal_req = 1'b0;
    m_cal = 1;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (filt_x !== 16'd0 || filt_y !== 16'd0 || filt_z !== 16'd0) begin
      n_fail++; $display("FAIL %s_filt: got %0d %0d %0d want 0 0 0", tag, filt_x, filt_y, filt_z);
    end
    n_checks++;
    if (filt_valid !== 1'b0 || cal_done !== 1'b0 || busy !== 1'b0 || drop_flag !== 1'b0 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_ctrl: fv=%b cd=%b busy=%b drop=%b led=%h want all 0", tag, filt_valid, cal_done, busy, drop_flag, led);
    end
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(negedge CLOCK_50);
    check_all_zero("reset_held");
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_all_zero("reset_released");
  endtask

  task automatic test_constant();
    for (int s = 0; s < NS; s++) accept_sample(100, -50, 256, 0, 2);
  endtask

  task automatic test_floor();
    for (int s = 0; s < NS; s++) accept_sample(s, $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100, 0, $urandom_range(0, 2));
    for (int s = 0; s < NS; s++) accept_sample(-1 - s, $urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100, 0, $urandom_range(0, 2));
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < NS; s++) accept_sample(rnd16(), rnd16(), rnd16(), 0, $urandom_range(0, 2));
  endtask

  task automatic test_calibration();
    pulse_cal();
    for (int s = 0; s < NS; s++) accept_sample(40, -20, 300, 0, $urandom_range(0, 2));
    for (int s = 0; s < NS; s++) accept_sample(41, -20, 300, 0, $urandom_range(0, 2));
  endtask

  task automatic test_saturation();
    pulse_cal();
    for (int s = 0; s < NS; s++) accept_sample(-32768, 0, 0, 0, 0);
    for (int s = 0; s < NS; s++) accept_sample(32767, 0, 0, 0, 0);
  endtask

  task automatic test_drop();
    for (int s = 0; s < NS; s++) begin
      if (s == 4) begin
        clear_flags = 1'b1;
        @(negedge CLOCK_50);
        clear_flags = 1'b0;
        n_checks++;
        if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL drop_flag_clear: got %b want 0", drop_flag); end
      end
      accept_sample(rnd16(), rnd16(), rnd16(), (s == 1) ? 1 : ((s == 4) ? 2 : 0), $urandom_range(0, 2));
    end
    n_checks++;
    if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL drop_flag_sticky: got %b want 1", drop_flag); end
    clear_flags = 1'b1;
    @(negedge CLOCK_50);
    clear_flags = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    pulse_cal();
    for (int s = 0; s < 4; s++) accept_sample(rnd16(), rnd16(), rnd16(), 0, 0);
    sample_valid = 1'b1;
    accel_x_in = 16'sd1234; accel_y_in = 16'sd1234; accel_z_in = 16'sd1234;
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    #1 check_all_zero("reset_mid");
    model_clear();
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    for (int s = 0; s < NS; s++) accept_sample(10, 10, 10, 0, $urandom_range(0, 2));
  endtask

  initial begin
    test_reset();
    test_constant();
    test_floor();
    test_random();
    test_calibration();
    test_random();
    test_saturation();
    test_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
